// File: rtl/obi_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : obi_apb_pkg
// Purpose : Shared types and constants for the OBI-to-APB bridge.
//           apb_state_e       - bridge FSM state encoding (IDLE/SETUP/ACCESS)
//           DEFAULT_ERR_RDATA - read data returned on slave error or timeout
//           TO_CNT_W          - width of the optional ACCESS-phase wait counter
// Revision: 1.0 - initial release
// ============================================================================
package obi_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_e;

    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'h0BAD_C0DE;
    localparam int unsigned TO_CNT_W          = 16;

endpackage : obi_apb_pkg
`default_nettype wire

// File: rtl/obi_apb_timeout.sv
`default_nettype none
// ============================================================================
// Module  : obi_apb_timeout
// Purpose : ACCESS-phase wait counter. Cleared while the bridge is in SETUP
//           (i.e. on entry to ACCESS), counts ACCESS cycles without pready,
//           and flags expiry once TIMEOUT_CYCLES waits have been counted.
//           Only instantiated when OBI_APB_TIMEOUT_EN is defined.
// Ports   : clk_i     - clock
//           rst_i     - synchronous reset, active-high
//           start_i   - bridge is in SETUP; clears the counter
//           active_i  - bridge is in ACCESS
//           pready_i  - APB ready
//           expired_o - wait limit reached in the current ACCESS cycle
// Revision: 1.0 - initial release
// ============================================================================
module obi_apb_timeout
    import obi_apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic active_i,
    input  logic pready_i,
    output logic expired_o
);

    localparam logic [TO_CNT_W-1:0] c_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);

    logic [TO_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            r_cnt <= '0;
        end else if (active_i && !pready_i) begin
            r_cnt <= r_cnt + TO_CNT_W'(1);
        end
    end

    assign expired_o = active_i && (r_cnt == c_LIMIT);

endmodule : obi_apb_timeout
`default_nettype wire

// File: rtl/obi_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module  : obi_apb_bridge
// Purpose : Converts one OBI slave channel into an APB3-style peripheral bus.
//           gnt is held low for the whole APB transfer and pulses only in the
//           completing ACCESS cycle; rvalid/rdata follow one cycle later.
//           Optional ACCESS-phase timeout: define OBI_APB_TIMEOUT_EN.
// Ports   : clk_i, rst_i (sync, active-high)
//           OBI  : obi_req_i, obi_gnt_o, obi_rvalid_o, obi_we_i, obi_be_i,
//                  obi_addr_i, obi_wdata_i, obi_rdata_o
//           APB  : paddr_o, psel_o, penable_o, pwrite_o, pstrb_o, pwdata_o,
//                  prdata_i, pready_i, pslverr_i
//           Err  : err_o (sticky), err_clr_i (set wins over clear)
// Revision: 1.0 - initial release
// ============================================================================
module obi_apb_bridge
    import obi_apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        obi_req_i,
    output logic        obi_gnt_o,
    output logic        obi_rvalid_o,
    input  logic        obi_we_i,
    input  logic [3:0]  obi_be_i,
    input  logic [31:0] obi_addr_i,
    input  logic [31:0] obi_wdata_i,
    output logic [31:0] obi_rdata_o,
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [3:0]  pstrb_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i,
    output logic        err_o,
    input  logic        err_clr_i
);

    apb_state_e  r_state;
    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [3:0]  r_pstrb;
    logic        r_psel;
    logic        r_penable;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_in_access;
    logic        w_expired;
    logic        w_done;
    logic        w_slverr;
    logic        w_match;
    logic        w_gnt;
    logic        w_err_set;
    logic [31:0] w_rdata_nxt;

    assign w_in_access = (r_state == ST_ACCESS);

`ifdef OBI_APB_TIMEOUT_EN
    obi_apb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (r_state == ST_SETUP),
        .active_i  (w_in_access),
        .pready_i  (pready_i),
        .expired_o (w_expired)
    );
`else
    logic w_timeout_unused;
    assign w_timeout_unused = (TIMEOUT_CYCLES != 0);
    assign w_expired        = 1'b0;
`endif

    // A real pready always wins over an expiry in the same cycle.
    assign w_done   = w_in_access && (pready_i || w_expired);
    assign w_slverr = pready_i ? pslverr_i : 1'b1;

    // The upstream may have switched master or dropped req while we waited;
    // only grant the request we actually put on the APB bus.
    assign w_match  = obi_req_i
                   && (obi_addr_i  == r_addr)
                   && (obi_we_i    == r_we)
                   && (obi_be_i    == r_be)
                   && (obi_wdata_i == r_wdata);

    // gnt is sampled combinationally upstream; suppress it during reset so a
    // transfer aborted by reset never completes.
    assign w_gnt       = w_done && w_match && !rst_i;
    assign w_err_set   = w_done && (w_slverr || !w_match);
    assign w_rdata_nxt = w_slverr ? ERR_RDATA : (r_we ? 32'h0 : prdata_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_pstrb   <= '0;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rvalid <= w_gnt;
            if (w_gnt) begin
                r_rdata <= w_rdata_nxt;
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (obi_req_i) begin
                        r_addr  <= obi_addr_i;
                        r_we    <= obi_we_i;
                        r_be    <= obi_be_i;
                        r_wdata <= obi_wdata_i;
                        r_pstrb <= obi_we_i ? obi_be_i : 4'b0000;
                        r_psel  <= 1'b1;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign obi_gnt_o    = w_gnt;
    assign obi_rvalid_o = r_rvalid;
    assign obi_rdata_o  = r_rdata;
    assign paddr_o      = r_addr;
    assign psel_o       = r_psel;
    assign penable_o    = r_penable;
    assign pwrite_o     = r_we;
    assign pstrb_o      = r_pstrb;
    assign pwdata_o     = r_wdata;
    assign err_o        = r_err;

endmodule : obi_apb_bridge
`default_nettype wire
